// File: rtl/calc_disp_pkg.sv
// Shared constants, glyph codes and types for the calculator display path.
package calc_disp_pkg;

    localparam int unsigned GLYPH_W = 7;
    localparam int unsigned CODE_W  = 6;

    localparam logic [CODE_W-1:0] CH_MINUS = 6'h0A;
    localparam logic [CODE_W-1:0] CH_E     = 6'h0B;
    localparam logic [CODE_W-1:0] CH_EQ    = 6'h3A;
    localparam logic [CODE_W-1:0] CH_DIV   = 6'h3B;
    localparam logic [CODE_W-1:0] CH_MUL   = 6'h3C;
    localparam logic [CODE_W-1:0] CH_PLUS  = 6'h3E;
    localparam logic [CODE_W-1:0] CH_BLANK = 6'h3F;

    localparam logic [7:0] DOT_MASK = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_SEND,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic              dot;
        logic [CODE_W-1:0] code;
    } slot_t;

endpackage

// File: rtl/disp_text_buf.sv
// Text line storage: one glyph code plus decimal-point flag per character slot.
module disp_text_buf
    import calc_disp_pkg::*;
#(
    parameter int unsigned       NCHAR      = 8,
    parameter logic [CODE_W-1:0] BLANK_CODE = CH_BLANK
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [$clog2(NCHAR)-1:0] wr_addr_i,
    input  slot_t                    wr_slot_i,
    input  logic [$clog2(NCHAR)-1:0] rd_addr_i,
    output slot_t                    rd_slot_o
);

    slot_t mem_q [NCHAR];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NCHAR); i++) begin
                mem_q[i] <= '{dot: 1'b0, code: BLANK_CODE};
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_slot_i;
        end
    end

    assign rd_slot_o = mem_q[rd_addr_i];

endmodule

// File: rtl/glyph_column_streamer.sv
// Walks the text line through the external glyph ROM and streams 7 column bytes per
// character to the display driver over a valid/ready link.
module glyph_column_streamer
    import calc_disp_pkg::*;
#(
    parameter int unsigned       NCHAR      = 8,
    parameter logic [CODE_W-1:0] BLANK_CODE = CH_BLANK
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(NCHAR)-1:0] wr_addr,
    input  logic [CODE_W-1:0]        wr_code,
    input  logic                     wr_dot,
    input  logic                     frame_start,
    output logic                     busy,
    output logic [CODE_W-1:0]        rom_code,
    input  logic [7:0]               rom_col0,
    input  logic [7:0]               rom_col1,
    input  logic [7:0]               rom_col2,
    input  logic [7:0]               rom_col3,
    input  logic [7:0]               rom_col4,
    input  logic [7:0]               rom_col5,
    input  logic [7:0]               rom_col6,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [7:0]               pix_data,
    output logic                     pix_first,
    output logic                     pix_last,
    output logic                     frame_done
);

    localparam int unsigned   AW       = $clog2(NCHAR);
    localparam logic [AW-1:0] LAST_IDX = AW'(NCHAR - 1);
    localparam logic [2:0]    LAST_COL = 3'(GLYPH_W - 1);

    state_e              state_q;
    logic [AW-1:0]       idx_q;
    logic [2:0]          cnt_q;
    logic                dot_q;
    logic [CODE_W-1:0]   rom_code_q;
    logic [7:0]          col_buf_q [GLYPH_W];
    logic                busy_q;
    logic                pix_valid_q;
    logic [7:0]          pix_data_q;
    logic                pix_first_q;
    logic                pix_last_q;
    logic                frame_done_q;
    slot_t               rd_slot;
    logic [7:0]          col0_dotted;

    disp_text_buf #(
        .NCHAR      (NCHAR),
        .BLANK_CODE (BLANK_CODE)
    ) u_text_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_slot_i ('{dot: wr_dot, code: wr_code}),
        .rd_addr_i (idx_q),
        .rd_slot_o (rd_slot)
    );

    // Decimal point lives in the dot row of the character's first column.
    assign col0_dotted = rom_col0 | (dot_q ? DOT_MASK : 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            dot_q        <= 1'b0;
            rom_code_q   <= BLANK_CODE;
            for (int i = 0; i < int'(GLYPH_W); i++) begin
                col_buf_q[i] <= 8'h00;
            end
            busy_q       <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= 8'h00;
            pix_first_q  <= 1'b0;
            pix_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    rom_code_q <= rd_slot.code;
                    dot_q      <= rd_slot.dot;
                    state_q    <= ST_LATCH;
                end
                ST_LATCH: begin
                    col_buf_q[0] <= col0_dotted;
                    col_buf_q[1] <= rom_col1;
                    col_buf_q[2] <= rom_col2;
                    col_buf_q[3] <= rom_col3;
                    col_buf_q[4] <= rom_col4;
                    col_buf_q[5] <= rom_col5;
                    col_buf_q[6] <= rom_col6;
                    cnt_q        <= '0;
                    pix_valid_q  <= 1'b1;
                    pix_data_q   <= col0_dotted;
                    pix_first_q  <= (idx_q == '0);
                    pix_last_q   <= 1'b0;
                    state_q      <= ST_SEND;
                end
                ST_SEND: begin
                    // pix_valid is always high here, so ready alone completes a transfer.
                    if (pix_ready) begin
                        if (cnt_q == LAST_COL) begin
                            pix_valid_q <= 1'b0;
                            pix_first_q <= 1'b0;
                            pix_last_q  <= 1'b0;
                            if (idx_q == LAST_IDX) begin
                                state_q <= ST_DONE;
                            end else begin
                                idx_q   <= idx_q + AW'(1);
                                state_q <= ST_FETCH;
                            end
                        end else begin
                            cnt_q       <= cnt_q + 3'd1;
                            pix_data_q  <= col_buf_q[cnt_q + 3'd1];
                            pix_first_q <= 1'b0;
                            pix_last_q  <= (idx_q == LAST_IDX) && (cnt_q == LAST_COL - 3'd1);
                        end
                    end
                end
                ST_DONE: begin
                    frame_done_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign rom_code   = rom_code_q;
    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_first  = pix_first_q;
    assign pix_last   = pix_last_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_glyph_column_streamer.sv
// Scoreboard bench for glyph_column_streamer with a stub glyph ROM and a random-ready sink.
module tb_glyph_column_streamer;
    import calc_disp_pkg::*;

    localparam int NC = 8;

    typedef struct {
        int         k;
        int         a;
        logic [5:0] c;
        logic       d;
    } wr_ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [5:0] wr_code;
    logic       wr_dot;
    logic       frame_start;
    logic       busy;
    logic [5:0] rom_code;
    logic [7:0] rom_cols [7];
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic       pix_first;
    logic       pix_last;
    logic       frame_done;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         nbytes   = 0;
    bit         rand_ready = 1'b0;
    bit         stalled    = 1'b0;
    logic [9:0] exp_q [$];
    logic [9:0] e;
    logic [7:0] cap [56];
    logic [5:0] mcode [NC];
    logic       mdot  [NC];
    logic [5:0] ecode [NC];
    logic       edot  [NC];
    wr_ev_t     sched [$];
    int         lat;

    always #5 clk = ~clk;

    glyph_column_streamer #(.NCHAR(NC), .BLANK_CODE(CH_BLANK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_code     (wr_code),
        .wr_dot      (wr_dot),
        .frame_start (frame_start),
        .busy        (busy),
        .rom_code    (rom_code),
        .rom_col0    (rom_cols[0]),
        .rom_col1    (rom_cols[1]),
        .rom_col2    (rom_cols[2]),
        .rom_col3    (rom_cols[3]),
        .rom_col4    (rom_cols[4]),
        .rom_col5    (rom_cols[5]),
        .rom_col6    (rom_cols[6]),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_first   (pix_first),
        .pix_last    (pix_last),
        .frame_done  (frame_done)
    );

    // Stub glyph ROM; leftmost byte of each literal is col0.
    function automatic logic [7:0] rom_byte(input logic [5:0] code, input int col);
        logic [55:0] g;
        case (code)
            6'h00:    g = 56'h00_3E_51_49_45_3E_00;
            6'h01:    g = 56'h00_00_00_42_7F_40_00;
            6'h02:    g = 56'h00_42_61_51_49_46_00;
            6'h03:    g = 56'h00_21_41_45_4B_31_00;
            6'h05:    g = 56'h00_27_45_45_45_39_00;
            CH_MINUS: g = 56'h00_08_08_08_08_08_00;
            CH_E:     g = 56'h00_7F_49_49_49_41_00;
            CH_EQ:    g = 56'h00_14_14_14_14_14_00;
            CH_PLUS:  g = 56'h00_08_08_3E_08_08_00;
            default:  g = 56'h0;
        endcase
        return g[(6 - col) * 8 +: 8];
    endfunction

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            rom_cols[i] = rom_byte(rom_code, i);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_exp();
        for (int i = 0; i < NC; i++) begin
            ecode[i] = mcode[i];
            edot[i]  = mdot[i];
        end
    endtask

    task automatic push_frame();
        logic [7:0] b;
        for (int c = 0; c < NC; c++) begin
            for (int col = 0; col < 7; col++) begin
                b = rom_byte(ecode[c], col);
                if (col == 0 && edot[c]) b = b | 8'h80;
                exp_q.push_back({1'(c == 0 && col == 0), 1'(c == NC - 1 && col == 6), b});
            end
        end
    endtask

    task automatic write_slot(input int a, input logic [5:0] c, input logic d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'(a); wr_code = c; wr_dot = d;
        @(negedge clk);
        wr_en = 1'b0;
        mcode[a] = c;
        mdot[a]  = d;
    endtask

    // k counts clock edges after the one that sampled frame_start.
    task automatic run_frame(input bit spam, input int rst_at, output int lat_o);
        int k;
        bit quit;
        nbytes = 0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        k = 0;
        quit = 1'b0;
        while (!frame_done && k < 3000 && !quit) begin
            if (rst_at >= 0 && nbytes >= rst_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_valid", 32'(pix_valid), 32'd0);
                check_eq("rst_done", 32'(frame_done), 32'd0);
                quit = 1'b1;
            end else begin
                if (k == 1) check_eq("busy_mid", 32'(busy), 32'd1);
                frame_start = spam ? 1'($urandom_range(0, 2) == 0) : 1'(k == 72);
                wr_en = 1'b0;
                foreach (sched[i]) begin
                    if (sched[i].k == k) begin
                        wr_en = 1'b1; wr_addr = 3'(sched[i].a);
                        wr_code = sched[i].c; wr_dot = sched[i].d;
                    end
                end
                @(negedge clk);
                k++;
            end
        end
        frame_start = 1'b0;
        wr_en = 1'b0;
        lat_o = k;
        if (!quit) begin
            check_eq("frame_done_seen", 32'(frame_done), 32'd1);
            check_eq("bytes_per_frame", 32'(nbytes), 32'd56);
            @(negedge clk);
            check_eq("done_pulse", 32'(frame_done), 32'd0);
            check_eq("busy_after", 32'(busy), 32'd0);
            check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        end
    endtask

    // Sink: picks ready, scores every transfer, and checks held outputs while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) check_eq("stall_valid", 32'(pix_valid), 32'd1);
            pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix_valid && !pix_ready && exp_q.size() != 0) begin
                check_eq("stall_hold", 32'({pix_first, pix_last, pix_data}), 32'(exp_q[0]));
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_byte", 32'(pix_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_byte", 32'({pix_first, pix_last, pix_data}), 32'(e));
                    if (nbytes < 56) cap[nbytes] = pix_data;
                    nbytes++;
                end
            end
            stalled = pix_valid && !pix_ready;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [5:0] txt [NC];
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_code = '0; wr_dot = 1'b0;
        frame_start = 1'b0; pix_ready = 1'b1;
        for (int i = 0; i < NC; i++) begin
            mcode[i] = CH_BLANK;
            mdot[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_valid", 32'(pix_valid), 32'd0);
        check_eq("reset_done", 32'(frame_done), 32'd0);
        check_eq("reset_rom_code", 32'(rom_code), 32'h3F);
        rst_n = 1'b1;

        // Blank line, frame latency
        load_exp(); push_frame();
        run_frame(1'b0, -1, lat);
        check_eq("t1_latency", 32'(lat), 32'd73);
        check_eq("t1_byte0", 32'(cap[0]), 32'h00);

        // "12+3=15-"
        txt = '{6'h01, 6'h02, CH_PLUS, 6'h03, CH_EQ, 6'h01, 6'h05, CH_MINUS};
        for (int i = 0; i < NC; i++) write_slot(i, txt[i], 1'b0);
        load_exp(); push_frame();
        run_frame(1'b0, -1, lat);
        check_eq("t2_latency", 32'(lat), 32'd73);
        check_eq("t2_byte1", 32'(cap[1]), 32'h00);
        check_eq("t2_byte2", 32'(cap[2]), 32'h00);
        check_eq("t2_byte3", 32'(cap[3]), 32'h42);
        check_eq("t2_byte4", 32'(cap[4]), 32'h7F);
        check_eq("t2_plus_col3", 32'(cap[17]), 32'h3E);
        check_eq("t2_c7_col1", 32'(cap[50]), 32'h08);

        // Zero with decimal point in slot 0
        write_slot(0, 6'h00, 1'b1);
        load_exp(); push_frame();
        run_frame(1'b0, -1, lat);
        check_eq("t3_byte0", 32'(cap[0]), 32'h80);
        check_eq("t3_byte1", 32'(cap[1]), 32'h3E);
        check_eq("t3_byte2", 32'(cap[2]), 32'h51);
        check_eq("t3_byte3", 32'(cap[3]), 32'h49);
        check_eq("t3_byte4", 32'(cap[4]), 32'h45);
        check_eq("t3_byte5", 32'(cap[5]), 32'h3E);

        // Random back-pressure plus frame_start spam while busy
        write_slot(0, 6'h01, 1'b0);
        rand_ready = 1'b1;
        load_exp(); push_frame();
        run_frame(1'b1, -1, lat);
        rand_ready = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("t4_idle_busy", 32'(busy), 32'd0);
        check_eq("t4_no_second_frame", 32'(exp_q.size()), 32'd0);

        // Mid-frame writes: ahead of the walk, behind it, and in the fetch cycle itself
        sched.push_back('{k: 21, a: 5, c: CH_E,  d: 1'b0});
        sched.push_back('{k: 30, a: 1, c: 6'h05, d: 1'b0});
        sched.push_back('{k: 36, a: 4, c: 6'h00, d: 1'b1});
        load_exp();
        ecode[5] = CH_E;
        push_frame();
        run_frame(1'b0, -1, lat);
        check_eq("t5_e_now", 32'(cap[36]), 32'h7F);
        check_eq("t5_slot1_old", 32'(cap[8]), 32'h42);
        check_eq("t5_slot4_old", 32'(cap[29]), 32'h14);
        foreach (sched[i]) begin
            mcode[sched[i].a] = sched[i].c;
            mdot[sched[i].a]  = sched[i].d;
        end
        sched.delete();
        load_exp(); push_frame();
        run_frame(1'b0, -1, lat);
        check_eq("t5_slot1_new", 32'(cap[8]), 32'h27);
        check_eq("t5_slot4_new", 32'(cap[28]), 32'h80);

        // Reset in the middle of a frame
        load_exp(); push_frame();
        run_frame(1'b0, 20, lat);
        exp_q.delete();
        for (int i = 0; i < NC; i++) begin
            mcode[i] = CH_BLANK;
            mdot[i]  = 1'b0;
        end
        @(negedge clk);
        check_eq("t6_rom_code", 32'(rom_code), 32'h3F);
        rst_n = 1'b1;
        load_exp(); push_frame();
        run_frame(1'b0, -1, lat);
        check_eq("t6_latency", 32'(lat), 32'd73);
        check_eq("t6_blank0", 32'(cap[0]), 32'h00);
        check_eq("t6_blank_c0_col3", 32'(cap[3]), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
